// File: rtl/axi4_cmd_master_pkg.sv
// Shared types and AXI constants for the single-outstanding AXI4 command master.
package axi4_cmd_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdD,
    StWrAw,
    StWrB,
    StRsp
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR      = 2'b01;
  localparam logic [2:0] SIZE_8B         = 3'b011;

endpackage

// File: rtl/axi4_cmd_master.sv
// Single-outstanding AXI4 initiator: one valid/ready command becomes one single-beat
// 64-bit read or write, and yields exactly one response.
module axi4_cmd_master
  import axi4_cmd_master_pkg::*;
#(
  parameter int unsigned TAGW    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            aclk,
  input  logic            rst_l,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [31:0]     cmd_addr,
  input  logic [63:0]     cmd_wdata,
  input  logic [7:0]      cmd_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [63:0]     rsp_rdata,
  output logic [1:0]      rsp_resp,
  output logic            rsp_err,
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [TAGW-1:0] arid,
  output logic [7:0]      arlen,
  output logic [1:0]      arburst,
  output logic [2:0]      arsize,
  input  logic            rvalid,
  output logic            rready,
  input  logic [63:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic [TAGW-1:0] rid,
  input  logic            rlast,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     awaddr,
  output logic [TAGW-1:0] awid,
  output logic [7:0]      awlen,
  output logic [1:0]      awburst,
  output logic [2:0]      awsize,
  output logic            wvalid,
  input  logic            wready,
  output logic [63:0]     wdata,
  output logic [7:0]      wstrb,
  output logic            wlast,
  input  logic            bvalid,
  output logic            bready,
  input  logic [1:0]      bresp,
  input  logic [TAGW-1:0] bid
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e          state_q, state_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            progress, expire, timeout_hit, busy;
  logic            cmd_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs;

  logic [31:0]     addr_q;
  logic [63:0]     wdata_q, rdata_q;
  logic [7:0]      wstrb_q;
  logic [TAGW-1:0] id_q, tag_q;
  logic [1:0]      resp_q;
  logic            err_q;

  assign cmd_hs = cmd_valid & cmd_ready;
  assign ar_hs  = arvalid & arready;
  assign r_hs   = rvalid & rready;
  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign b_hs   = bvalid & bready;

  assign busy        = (state_q == StRdA) || (state_q == StRdD) ||
                       (state_q == StWrAw) || (state_q == StWrB);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    progress  = 1'b0;
    expire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d   = cmd_write ? StWrAw : StRdA;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StRdA: begin
        if (ar_hs) begin
          state_d  = StRdD;
          progress = 1'b1;
        end else if (timeout_hit) begin
          state_d = StRsp;
          expire  = 1'b1;
        end
      end
      StRdD: begin
        if (r_hs) begin
          state_d  = StRsp;
          progress = 1'b1;
        end else if (timeout_hit) begin
          state_d = StRsp;
          expire  = 1'b1;
        end
      end
      StWrAw: begin
        // AW and W complete independently; either handshake counts as progress.
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        progress  = aw_hs | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = StWrB;
        end else if (!progress && timeout_hit) begin
          state_d = StRsp;
          expire  = 1'b1;
        end
      end
      StWrB: begin
        if (b_hs) begin
          state_d  = StRsp;
          progress = 1'b1;
        end else if (timeout_hit) begin
          state_d = StRsp;
          expire  = 1'b1;
        end
      end
      StRsp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    cnt_d = '0;
    if (busy && (state_d == state_q) && !progress) cnt_d = cnt_q + CntW'(1);
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    arvalid   = (state_q == StRdA);
    rready    = (state_q == StRdD);
    awvalid   = (state_q == StWrAw) && !aw_done_q;
    wvalid    = (state_q == StWrAw) && !w_done_q;
    bready    = (state_q == StWrB);
    rsp_valid = (state_q == StRsp);
  end

  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      id_q    <= '0;
      tag_q   <= '0;
      rdata_q <= '0;
      resp_q  <= AXI_RESP_OKAY;
      err_q   <= 1'b0;
    end else begin
      if (cmd_hs) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        id_q    <= tag_q;
        tag_q   <= tag_q + TAGW'(1);
        rdata_q <= '0;
        resp_q  <= AXI_RESP_OKAY;
        err_q   <= 1'b0;
      end
      if (r_hs) begin
        rdata_q <= rdata;
        resp_q  <= rresp;
        err_q   <= (rid != id_q) | ~rlast;
      end
      if (b_hs) begin
        resp_q <= bresp;
        err_q  <= (bid != id_q);
      end
      if (expire) begin
        resp_q <= AXI_RESP_SLVERR;
        err_q  <= 1'b1;
      end
    end
  end

  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign arid      = id_q;
  assign awid      = id_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wlast     = 1'b1;
  assign arlen     = 8'd0;
  assign awlen     = 8'd0;
  assign arburst   = BURST_INCR;
  assign awburst   = BURST_INCR;
  assign arsize    = SIZE_8B;
  assign awsize    = SIZE_8B;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_axi4_cmd_master.sv
// Bench for axi4_cmd_master: directed vector table, randomized transactions against a
// memory-level reference model, and a mid-transaction reset sequence.
module tb_axi4_cmd_master;
  import axi4_cmd_master_pkg::*;

  localparam int unsigned TAGW    = 4;
  localparam int unsigned TIMEOUT = 16;

  logic aclk = 1'b0;
  logic rst_l;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic [7:0]  cmd_wstrb;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic arvalid, arready, rvalid, rready, rlast, awvalid, awready;
  logic wvalid, wready, wlast, bvalid, bready;
  logic [31:0] araddr, awaddr;
  logic [TAGW-1:0] arid, rid, awid, bid;
  logic [7:0]  arlen, awlen, wstrb;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic [2:0]  arsize, awsize;
  logic [63:0] rdata, wdata;

  always #5 aclk = ~aclk;

  axi4_cmd_master #(.TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
    .aclk(aclk), .rst_l(rst_l),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_err(rsp_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arburst(arburst), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awburst(awburst), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
  );

  // Slave behaviour per transaction; ar_d < 0 means arready never rises.
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          ar_d, r_d, aw_d, w_d, b_d;
    int          id_off;
    bit          rlast_v;
    logic [1:0]  resp_v;
    logic [1:0]  exp_resp;
    bit          exp_err;
    bit          tmo;
  } vec_t;

  vec_t cfg;
  int   checks = 0, failures = 0;
  int   clr_gen = 0, clr_seen = 0;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // AXI slave: decisions made on the falling edge, handshakes land on the next rising edge.
  bit ar_fire, r_pend, r_fire, aw_fire, w_fire, aw_got, w_got, b_pend, b_fire, b_done;
  bit unstable;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, arc, awc, wc;
  logic [31:0] s_raddr, s_waddr;
  logic [TAGW-1:0] s_rid, s_wid;
  logic [63:0] s_wd;
  logic [7:0]  s_ws;
  logic [63:0] smem [logic [28:0]];

  always @(negedge aclk) begin
    if (!rst_l || clr_seen != clr_gen) begin
      clr_seen = clr_gen;
      {ar_fire, r_pend, r_fire, aw_fire, w_fire, aw_got, w_got, b_pend, b_fire, b_done} = '0;
      unstable = 1'b0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; arc = 0; awc = 0; wc = 0;
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      rdata = '0; rresp = '0; rid = '0; rlast = 0; bresp = '0; bid = '0;
    end else begin
      if (ar_fire) begin r_pend = 1; r_cnt = 0; end
      ar_fire = 0; arready = 0;
      if (arvalid) begin
        if (arc == 0) begin s_raddr = araddr; s_rid = arid; end
        else if (araddr != s_raddr || arid != s_rid) unstable = 1;
        arc++;
        if (cfg.ar_d >= 0 && ar_cnt >= cfg.ar_d) begin arready = 1; ar_fire = 1; end
        else ar_cnt++;
      end
      if (r_fire) r_pend = 0;
      r_fire = 0; rvalid = 0;
      if (r_pend) begin
        if (r_cnt >= cfg.r_d) begin
          rvalid = 1;
          rdata  = smem.exists(s_raddr[31:3]) ? smem[s_raddr[31:3]] : 64'd0;
          rid    = s_rid + TAGW'(cfg.id_off);
          rlast  = cfg.rlast_v;
          rresp  = cfg.resp_v;
          r_fire = rready;
        end else r_cnt++;
      end
      if (aw_fire) aw_got = 1;
      if (w_fire) begin
        w_got = 1;
        smem[s_waddr[31:3]] = merge(smem.exists(s_waddr[31:3]) ? smem[s_waddr[31:3]] : 64'd0,
                                    s_wd, s_ws);
      end
      aw_fire = 0; w_fire = 0; awready = 0; wready = 0;
      if (awvalid) begin
        if (awc == 0) begin s_waddr = awaddr; s_wid = awid; end
        else if (awaddr != s_waddr || awid != s_wid) unstable = 1;
        awc++;
        if (aw_cnt >= cfg.aw_d) begin awready = 1; aw_fire = 1; end
        else aw_cnt++;
      end
      if (wvalid) begin
        if (wc == 0) begin s_wd = wdata; s_ws = wstrb; end
        else if (wdata != s_wd || wstrb != s_ws) unstable = 1;
        if (!wlast) unstable = 1;
        wc++;
        if (w_cnt >= cfg.w_d) begin wready = 1; w_fire = 1; end
        else w_cnt++;
      end
      if (aw_got && w_got && !b_pend && !b_done) begin b_pend = 1; b_cnt = 0; end
      if (b_fire) begin b_pend = 0; b_done = 1; end
      b_fire = 0; bvalid = 0;
      if (b_pend) begin
        if (b_cnt >= cfg.b_d) begin
          bvalid = 1;
          bid    = s_wid + TAGW'(cfg.id_off);
          bresp  = cfg.resp_v;
          b_fire = bready;
        end else b_cnt++;
      end
    end
  end

  // Reference model: flat memory plus the rolling tag.
  logic [63:0]     mmem [logic [28:0]];
  logic [TAGW-1:0] exp_tag;

  task automatic run_vec(input vec_t v, input int hold);
    int cyc, lat, exp_lat, mx;
    logic [63:0] exp_data;
    cfg = v;
    clr_gen++;
    mx = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
    exp_data = '0;
    if (!v.wr && !v.tmo)
      exp_data = mmem.exists(v.addr[31:3]) ? mmem[v.addr[31:3]] : 64'd0;
    exp_lat = v.tmo ? int'(TIMEOUT) + 1 : (v.wr ? 3 + mx + v.b_d : 3 + v.ar_d + v.r_d);
    cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    cmd_valid = 1;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin @(posedge aclk); #1; cyc++; end
    check("cmd_ready_idle", 96'(cmd_ready), 96'(1));
    @(posedge aclk); #1;
    cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(posedge aclk); #1; lat++; end
    check("rsp_valid", 96'(rsp_valid), 96'(1));
    check("latency", 96'(lat), 96'(exp_lat));
    check("rsp_fields", {rsp_rdata, rsp_resp, rsp_err}, {exp_data, v.exp_resp, v.exp_err});
    for (int i = 0; i < hold; i++) begin
      @(posedge aclk); #1;
      check("rsp_hold", {rsp_valid, rsp_rdata, rsp_resp, rsp_err},
            {1'b1, exp_data, v.exp_resp, v.exp_err});
    end
    rsp_ready = 1;
    @(posedge aclk); #1;
    rsp_ready = 0;
    check("rsp_drop", {rsp_valid, cmd_ready}, {1'b0, 1'b1});
    if (v.wr) begin
      check("awid", 96'(s_wid), 96'(exp_tag));
      check("aw_addr", 96'(s_waddr), 96'(v.addr));
      check("w_data", {s_wd, s_ws}, {v.wdata, v.wstrb});
      check("aw_w_cycles", {32'(awc), 32'(wc)}, {32'(v.aw_d + 1), 32'(v.w_d + 1)});
      if (!v.tmo) mmem[v.addr[31:3]] = merge(mmem.exists(v.addr[31:3]) ?
                                             mmem[v.addr[31:3]] : 64'd0, v.wdata, v.wstrb);
    end else begin
      check("arid", 96'(s_rid), 96'(exp_tag));
      check("ar_addr", 96'(s_raddr), 96'(v.addr));
      check("ar_cycles", 96'(arc), 96'(v.ar_d < 0 ? int'(TIMEOUT) : v.ar_d + 1));
    end
    check("chan_stable", 96'(unstable), 96'(0));
    exp_tag = exp_tag + TAGW'(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    vec_t v;
    rst_l = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0; exp_tag = '0;
    cfg = '{0, 32'h0, 64'h0, 8'h0, 0, 0, 0, 0, 0, 0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    repeat (3) @(posedge aclk);
    #1;
    check("reset_valids", {arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err}, 0);
    check("reset_regs", {araddr, arid, wdata, wstrb, rsp_rdata}, 0);
    check("reset_const", {arlen, awlen, arburst, awburst, arsize, awsize, wlast},
          {8'd0, 8'd0, 2'b01, 2'b01, 3'b011, 3'b011, 1'b1});
    check("reset_cmd_ready", 96'(cmd_ready), 96'(1));
    rst_l = 1;
    @(posedge aclk); #1;

    //        wr    addr          wdata                  strb   ar  r  aw w  b idoff rlast resp  exp   err tmo
    tbl[0]  = '{1'b1, 32'h0000_1000, 64'h1122334455667788, 8'hFF, 0, 0, 0, 0, 0, 0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_1000, 64'h0,                8'h00, 0, 0, 0, 0, 0, 0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'hD058_0000, 64'h0000000000000041, 8'h01, 0, 0, 0, 0, 0, 0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_2000, 64'hCAFEF00DDEADBEEF, 8'hFF, 0, 0, 0, 5, 0, 0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0000_2000, 64'h0,                8'h00,-1, 0, 0, 0, 0, 0, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 32'h0000_1000, 64'h0,                8'h00, 0, 0, 0, 0, 0, 1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 32'h0000_1000, 64'h0,                8'h00, 0, 1, 0, 0, 0, 0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_1000, 64'hAAAABBBBCCCCDDDD, 8'hF0, 0, 0, 3, 1, 2, 0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 32'h0000_1000, 64'h0,                8'h00, 2, 3, 0, 0, 0, 0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 32'h0000_2008, 64'h0123456789ABCDEF, 8'h3C, 0, 0, 0, 0, 1, 1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 32'h0000_2003, 64'h0,                8'h00, 1, 0, 0, 0, 0, 0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 32'h0000_3000, 64'h5555666677778888, 8'hFF, 0, 0, 2, 0, 0, 0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) run_vec(tbl[i], i % 3);

    for (int i = 0; i < 30; i++) begin
      v.wr      = 1'($urandom_range(0, 1));
      v.addr    = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd8;
      v.wdata   = {$urandom, $urandom};
      v.wstrb   = 8'($urandom);
      v.ar_d    = $urandom_range(0, 3);
      v.r_d     = $urandom_range(0, 3);
      v.aw_d    = $urandom_range(0, 3);
      v.w_d     = $urandom_range(0, 3);
      v.b_d     = $urandom_range(0, 3);
      v.id_off  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      v.rlast_v = 1'b1;
      v.resp_v  = $urandom_range(0, 1) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      v.exp_resp = v.resp_v;
      v.exp_err  = (v.id_off != 0);
      v.tmo      = 1'b0;
      run_vec(v, $urandom_range(0, 2));
    end

    // Reset while the read is waiting for its data beat.
    cfg = '{1'b0, 32'h1000, 64'h0, 8'h00, 0, 20, 0, 0, 0, 0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    clr_gen++;
    cmd_write = 0; cmd_addr = 32'h1000; cmd_valid = 1;
    @(posedge aclk); #1;
    cmd_valid = 0;
    repeat (2) begin @(posedge aclk); #1; end
    check("rready_pre_reset", {rready, arvalid}, {1'b1, 1'b0});
    rst_l = 0;
    #1;
    check("valids_in_reset", {arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err}, 0);
    check("regs_in_reset", {araddr, arid}, 0);
    repeat (2) @(posedge aclk);
    #1;
    rst_l = 1;
    exp_tag = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1;
      check("no_rsp_after_reset", {rsp_valid, cmd_ready}, {1'b0, 1'b1});
    end
    v = '{1'b0, 32'h1000, 64'h0, 8'h00, 0, 0, 0, 0, 0, 0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    run_vec(v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
